ahb_sram_slave: RTL and testbench

AHB-Lite responder containing a word-addressed SRAM array, with configurable wait states and byte/halfword/word writes. It sits on one slave port of `ahb_bus`: it takes the per-slave address, control and write-data outputs plus the broadcast HREADY, and returns read data, HREADYOUT and HRESP to the bus multiplexor. It ignores HBURST, HPROT and HMASTLOCK.

---
 rtl/ahb_sram_slave_if.sv | 29 ++
 rtl/ahb_sram_slave.sv | 133 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-port bundle for ahb_sram_slave: per-slave address/control/data
// from the bus, broadcast HREADY in, and the slave's response back out.
interface ahb_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  s_hsel_in;
    logic [ADDR_WIDTH-1:0] s_haddr_in;
    logic [1:0]            s_htrans_in;
    logic [2:0]            s_hsize_in;
    logic                  s_hwrite_in;
    logic [DATA_WIDTH-1:0] s_hwdata_in;
    logic                  s_hready_in;
    logic [DATA_WIDTH-1:0] s_hrdata_out;
    logic                  s_hready_out;
    logic                  s_hresp_out;

    modport slave (
        input  s_hsel_in, s_haddr_in, s_htrans_in, s_hsize_in,
               s_hwrite_in, s_hwdata_in, s_hready_in,
        output s_hrdata_out, s_hready_out, s_hresp_out
    );

    modport master (
        output s_hsel_in, s_haddr_in, s_htrans_in, s_hsize_in,
               s_hwrite_in, s_hwdata_in, s_hready_in,
        input  s_hrdata_out, s_hready_out, s_hresp_out
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: word array with byte/halfword/word writes,
// configurable wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    MEM_WORDS   = 1024,
    parameter int                    WAIT_STATES = 0
) (
    input logic                 clk,
    input logic                 rst,
    ahb_sram_slave_if.slave     bus
);
    localparam int                IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS * 4);
    localparam logic [3:0]        WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_be;
    logic                  r_write;
    logic                  r_hready;
    logic                  r_hresp;
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_below;
    logic                  w_oor;
    logic                  w_err;
    logic [3:0]            w_be;
    logic                  w_unused_ok;

    assign w_accept    = bus.s_hsel_in & bus.s_htrans_in[1] & bus.s_hready_in;
    assign w_off       = bus.s_haddr_in - BASE_ADDR;
    assign w_below     = bus.s_haddr_in < BASE_ADDR;
    assign w_oor       = {1'b0, w_off} >= LIMIT;
    assign w_unused_ok = bus.s_htrans_in[0];

    always_comb begin
        w_err = w_below | w_oor;
        w_be  = 4'b1111;
        case (bus.s_hsize_in)
            3'd0: w_be = 4'b0001 << bus.s_haddr_in[1:0];
            3'd1: begin
                w_be  = bus.s_haddr_in[1] ? 4'b1100 : 4'b0011;
                w_err = w_err | bus.s_haddr_in[0];
            end
            3'd2: w_err = w_err | (bus.s_haddr_in[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
    end

    // Accepts are only evaluated in states whose HREADYOUT is high; in WAIT and
    // ERR1 the bus HREADY is low, so any address phase there is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_be     <= '0;
            r_write  <= 1'b0;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_state  <= S_DATA;
                        r_cnt    <= '0;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: begin
                    if (w_accept) begin
                        r_idx   <= w_off[IDX_W+1:2];
                        r_be    <= w_be;
                        r_write <= bus.s_hwrite_in;
                        if (w_err) begin
                            r_state  <= S_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else if (WS != 4'd0) begin
                            r_state  <= S_WAIT;
                            r_cnt    <= WS;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b0;
                        end else begin
                            r_state  <= S_DATA;
                            r_hready <= 1'b1;
                            r_hresp  <= 1'b0;
                        end
                    end else begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Array is not reset; an async reset leaves IDLE so a pending write never lands.
    always_ff @(posedge clk) begin
        if (r_state == S_DATA && r_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= bus.s_hwdata_in[8*b +: 8];
                end
            end
        end
    end

    assign bus.s_hrdata_out = (r_state == S_DATA && !r_write) ? r_mem[r_idx] : '0;
    assign bus.s_hready_out = r_hready;
    assign bus.s_hresp_out  = r_hresp;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait instance at base 0 and one
// three-wait instance at base 0x100 with 16 words, sharing a single driver.
module tb_ahb_sram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'd0;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = '0;
    logic        ready;
    logic        resp;
    logic [31:0] rdata;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();

    assign if0.s_hsel_in   = hsel && !sel;
    assign if0.s_haddr_in  = haddr;
    assign if0.s_htrans_in = htrans;
    assign if0.s_hsize_in  = hsize;
    assign if0.s_hwrite_in = hwrite;
    assign if0.s_hwdata_in = hwdata;
    assign if0.s_hready_in = if0.s_hready_out;

    assign if1.s_hsel_in   = hsel && sel;
    assign if1.s_haddr_in  = haddr;
    assign if1.s_htrans_in = htrans;
    assign if1.s_hsize_in  = hsize;
    assign if1.s_hwrite_in = hwrite;
    assign if1.s_hwdata_in = hwdata;
    assign if1.s_hready_in = if1.s_hready_out;

    assign ready = sel ? if1.s_hready_out : if0.s_hready_out;
    assign resp  = sel ? if1.s_hresp_out  : if0.s_hresp_out;
    assign rdata = sel ? if1.s_hrdata_out : if0.s_hrdata_out;

    ahb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_0000),
        .MEM_WORDS(1024), .WAIT_STATES(0)
    ) u_dut0 (.clk(clk), .rst(rst), .bus(if0));

    ahb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_0100),
        .MEM_WORDS(16), .WAIT_STATES(3)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single non-pipelined transfer; returns low-ready cycle count and responses.
    task automatic xfer(input logic [31:0] a, input logic [2:0] s, input logic w,
                        input logic [31:0] wd, output int waits, output logic [31:0] rd,
                        output logic resp_first, output logic resp_last);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = s; hwrite = w; hwdata = '0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        waits = 0;
        resp_first = resp;
        while (!ready && waits < 40) begin
            waits++;
            @(posedge clk); #1;
        end
        rd = rdata;
        resp_last = resp;
        @(posedge clk); #1;
    endtask

    initial begin
        int          wt;
        logic [31:0] rd;
        logic        rf, rl;
        logic [31:0] ea [4];
        logic [2:0]  es [4];
        ea[0] = 32'h1;  es[0] = 3'd1;
        ea[1] = 32'h2;  es[1] = 3'd2;
        ea[2] = 32'h20; es[2] = 3'd3;
        ea[3] = 32'h1000; es[3] = 3'd2;

        #2 rst = 1'b1;
        #1;
        chk("rst_ready0", {31'd0, if0.s_hready_out}, 32'd1);
        chk("rst_resp0",  {31'd0, if0.s_hresp_out},  32'd0);
        chk("rst_rdata0", if0.s_hrdata_out,          32'd0);
        chk("rst_ready1", {31'd0, if1.s_hready_out}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Zero-wait instance: basic word write/read
        sel = 1'b0;
        xfer(32'h10, 3'd2, 1'b1, 32'hDEADBEEF, wt, rd, rf, rl);
        chk("wr10_waits", wt, 0);
        chk("wr10_resp", {31'd0, rl}, 32'd0);
        xfer(32'h10, 3'd2, 1'b0, 32'h0, wt, rd, rf, rl);
        chk("rd10_waits", wt, 0);
        chk("rd10_data", rd, 32'hDEADBEEF);
        chk("rd10_resp", {31'd0, rl}, 32'd0);

        // Byte and halfword lane merging
        xfer(32'h20, 3'd2, 1'b1, 32'h0000_0000, wt, rd, rf, rl);
        xfer(32'h22, 3'd0, 1'b1, 32'h00AB_0000, wt, rd, rf, rl);
        xfer(32'h20, 3'd1, 1'b1, 32'h0000_1234, wt, rd, rf, rl);
        xfer(32'h20, 3'd2, 1'b0, 32'h0, wt, rd, rf, rl);
        chk("rd20_lanes", rd, 32'h00AB_1234);
        xfer(32'h27, 3'd0, 1'b1, 32'h5600_0000, wt, rd, rf, rl);
        xfer(32'h24, 3'd2, 1'b0, 32'h0, wt, rd, rf, rl);
        chk("rd24_byte3", rd[31:24], 32'h56);

        // Error responses; erroneous writes must not touch the array
        xfer(32'h0, 3'd2, 1'b1, 32'h1122_3344, wt, rd, rf, rl);
        for (int i = 0; i < 4; i++) begin
            xfer(ea[i], es[i], 1'b1, 32'hFFFF_FFFF, wt, rd, rf, rl);
            chk($sformatf("err%0d_resp_first", i), {31'd0, rf}, 32'd1);
            chk($sformatf("err%0d_low_cycles", i), wt, 1);
            chk($sformatf("err%0d_resp_last", i), {31'd0, rl}, 32'd1);
        end
        xfer(32'h0, 3'd2, 1'b0, 32'h0, wt, rd, rf, rl);
        chk("err_rd0_data", rd, 32'h1122_3344);
        chk("err_rd0_okay", {31'd0, rl}, 32'd0);
        xfer(32'h20, 3'd2, 1'b0, 32'h0, wt, rd, rf, rl);
        chk("err_rd20_data", rd, 32'h00AB_1234);

        // Non-accepted cycles: IDLE/BUSY with hsel, NONSEQ without hsel
        xfer(32'h40, 3'd2, 1'b1, 32'h0000_0077, wt, rd, rf, rl);
        hsel = 1'b1; htrans = 2'b00; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b1; hwdata = 32'h99;
        @(posedge clk); #1;
        chk("idle_ready", {31'd0, ready}, 32'd1);
        chk("idle_resp", {31'd0, resp}, 32'd0);
        htrans = 2'b01;
        @(posedge clk); #1;
        chk("busy_ready", {31'd0, ready}, 32'd1);
        hsel = 1'b0; htrans = 2'b10;
        @(posedge clk); #1;
        chk("nosel_ready", {31'd0, ready}, 32'd1);
        htrans = 2'b00;
        @(posedge clk); #1;
        xfer(32'h40, 3'd2, 1'b0, 32'h0, wt, rd, rf, rl);
        chk("nowrite_rd40", rd, 32'h0000_0077);

        // Back-to-back write then read of the same word
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b1;
        @(posedge clk); #1;
        hwdata = 32'h5; hwrite = 1'b0;
        chk("b2b_wr_ready", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        chk("b2b_rd_ready", {31'd0, ready}, 32'd1);
        chk("b2b_rd_data", rdata, 32'h5);
        @(posedge clk); #1;

        // Three-wait instance at base 0x100
        sel = 1'b1;
        xfer(32'h104, 3'd2, 1'b1, 32'hA5A5_A5A5, wt, rd, rf, rl);
        chk("ws_wr_waits", wt, 3);
        xfer(32'h108, 3'd2, 1'b1, 32'h0BAD_F00D, wt, rd, rf, rl);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h104; hsize = 3'd2; hwrite = 1'b0;
        @(posedge clk); #1;
        haddr = 32'h108;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ws_rd_low%0d", i), {31'd0, ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("ws_rd_ready", {31'd0, ready}, 32'd1);
        chk("ws_rd_data", rdata, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ws_pipe_low%0d", i), {31'd0, ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("ws_pipe_data", rdata, 32'h0BAD_F00D);
        @(posedge clk); #1;
        chk("ws_idle_ready", {31'd0, ready}, 32'd1);

        xfer(32'h0FC, 3'd2, 1'b0, 32'h0, wt, rd, rf, rl);
        chk("below_low_cycles", wt, 1);
        chk("below_resp", {31'd0, rf & rl}, 32'd1);
        xfer(32'h140, 3'd2, 1'b1, 32'hFFFF_FFFF, wt, rd, rf, rl);
        chk("above_low_cycles", wt, 1);
        chk("above_resp", {31'd0, rf & rl}, 32'd1);
        xfer(32'h100, 3'd2, 1'b0, 32'h0, wt, rd, rf, rl);
        chk("above_no_alias", {31'd0, rl}, 32'd0);

        // Reset during the wait phase of a write discards it
        xfer(32'h130, 3'd2, 1'b1, 32'h1, wt, rd, rf, rl);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h130; hsize = 3'd2; hwrite = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        chk("rstw_wait_low", {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstw_ready", {31'd0, ready}, 32'd1);
        chk("rstw_resp", {31'd0, resp}, 32'd0);
        chk("rstw_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(32'h130, 3'd2, 1'b0, 32'h0, wt, rd, rf, rl);
        chk("rstw_rd_waits", wt, 3);
        chk("rstw_rd_data", rd, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
